// File: rtl/vga_scanout_if.sv
// Framebuffer synchronous read port: address/enable out, 1-bit pixel back one cycle later.
interface vga_scanout_if #(
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  read_en;
  logic                  read_data;

  modport master (output read_addr, output read_en, input read_data);
  modport slave  (input read_addr, input read_en, output read_data);
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout of a 160x120 1-bpp framebuffer, each stored pixel shown as a 4x4 block.
// Counters -> address -> RAM -> colour; sync/de ride a 3-deep delay line to stay aligned.
module vga_scanout #(
  parameter int          ADDR_WIDTH = 15,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FRONT    = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BACK     = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FRONT    = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BACK     = 33
) (
  input  logic          clk_25,
  input  logic          reset,
  vga_scanout_if.master fb,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [11:0]   rgb,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [9:0]            h_cnt;
  logic [9:0]            v_cnt;
  logic                  visible;
  logic                  hs_raw;
  logic                  vs_raw;
  logic [7:0]            x_blk;
  logic [7:0]            y_blk;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic [2:0]            hs_pipe;
  logic [2:0]            vs_pipe;
  logic [2:0]            de_pipe;

  // S0: raster position
  always_ff @(posedge clk_25) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // y*160 + x as two shifts and adds; row stride is fixed by the framebuffer layout
  always_comb begin
    visible  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_raw   = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_raw   = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    x_blk    = h_cnt[9:2];
    y_blk    = v_cnt[9:2];
    pix_addr = (ADDR_WIDTH'(y_blk) << 7) + (ADDR_WIDTH'(y_blk) << 5) + ADDR_WIDTH'(x_blk);
  end

  // S1: framebuffer request
  always_ff @(posedge clk_25) begin
    if (reset) begin
      fb.read_addr <= '0;
      fb.read_en   <= 1'b0;
    end else begin
      fb.read_addr <= visible ? pix_addr : '0;
      fb.read_en   <= visible;
    end
  end

  always_ff @(posedge clk_25) begin
    if (reset) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      de_pipe <= '0;
    end else begin
      hs_pipe <= {hs_pipe[1:0], hs_raw};
      vs_pipe <= {vs_pipe[1:0], vs_raw};
      de_pipe <= {de_pipe[1:0], visible};
    end
  end

  // S3: de_pipe[1] is the visible flag that matches the read_data now on the bus
  always_ff @(posedge clk_25) begin
    if (reset) begin
      rgb <= '0;
    end else begin
      rgb <= de_pipe[1] ? (fb.read_data ? FG_COLOR : BG_COLOR) : '0;
    end
  end

  assign hsync = hs_pipe[2];
  assign vsync = vs_pipe[2];
  assign de    = de_pipe[2];

  // Undelayed origin decode; gated by reset so the counters parked at (0,0) during reset do not pulse
  assign frame_start = (h_cnt == '0) && (v_cnt == '0) && !reset;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: full-size timing instance plus a shrunk-timing instance for whole frames,
// both checked every cycle against an arithmetic raster model and a shared behavioural RAM.
module tb_vga_scanout;

  localparam logic [11:0] D_FG = 12'hFFF;
  localparam logic [11:0] D_BG = 12'h000;
  localparam logic [11:0] S_FG = 12'hA5C;
  localparam logic [11:0] S_BG = 12'h3F0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frc = 1'b0;
  always #20 clk = ~clk;

  logic mem [0:19199];
  logic q_d = 1'b0;
  logic q_s = 1'b0;

  int cyc    = 0;
  int phase  = 0;
  int errors = 0;
  int checks = 0;

  int d_hlow = 0, d_de = 0, d_vlow = 0, d_fs = 0, d_fall1 = -1, d_fall2 = -1;
  int s_hlow = 0, s_de = 0, s_vlow = 0, s_fs = 0, s_vf1 = -1, s_vf2 = -1;
  int blank_bad = 0, s_fg6 = 0, s_de6 = 0;
  logic prev_hs_d = 1'b1;
  logic prev_vs_s = 1'b1;

  typedef struct {
    int   h;
    int   v;
    int   addr;
    logic en;
  } vec_t;
  vec_t vecs [9];

  vga_scanout_if #(.ADDR_WIDTH(15)) fb_d ();
  vga_scanout_if #(.ADDR_WIDTH(15)) fb_s ();

  logic        hsync_d, vsync_d, de_d, fs_d;
  logic [11:0] rgb_d;
  logic        hsync_s, vsync_s, de_s, fs_s;
  logic [11:0] rgb_s;

  vga_scanout #(.ADDR_WIDTH(15)) dut_d (
    .clk_25(clk), .reset(rst), .fb(fb_d),
    .hsync(hsync_d), .vsync(vsync_d), .de(de_d), .rgb(rgb_d), .frame_start(fs_d)
  );

  vga_scanout #(
    .ADDR_WIDTH(15), .FG_COLOR(S_FG), .BG_COLOR(S_BG),
    .H_ACTIVE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_ACTIVE(24), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_s (
    .clk_25(clk), .reset(rst), .fb(fb_s),
    .hsync(hsync_s), .vsync(vsync_s), .de(de_s), .rgb(rgb_s), .frame_start(fs_s)
  );

  assign fb_d.read_data = frc ? 1'b1 : q_d;
  assign fb_s.read_data = frc ? 1'b1 : q_s;

  always @(posedge clk) begin
    if (fb_d.read_en) q_d <= mem[fb_d.read_addr];
    if (fb_s.read_en) q_s <= mem[fb_s.read_addr];
  end

  // cycles since the last edge that sampled reset high
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Expected {hsync,vsync,de,rgb,frame_start,read_en,read_addr} for a raster n cycles past reset.
  function automatic logic [31:0] model(input int hact, input int hfp, input int hsw, input int hbp,
                                        input int vact, input int vfp, input int vsw, input int vbp,
                                        input logic [11:0] fg, input logic [11:0] bg,
                                        input int n, input logic rst_now);
    int htot, vtot, h, v;
    logic hs, vs, vis, fs, en, px;
    logic [11:0] col;
    logic [14:0] addr;
    htot = hact + hfp + hsw + hbp;
    vtot = vact + vfp + vsw + vbp;
    h = n % htot;
    v = (n / htot) % vtot;
    fs = (h == 0) && (v == 0) && !rst_now;
    en = 1'b0;
    addr = '0;
    if (n >= 1) begin
      h = (n - 1) % htot;
      v = ((n - 1) / htot) % vtot;
      en = (h < hact) && (v < vact);
      if (en) addr = 15'((v / 4) * 160 + h / 4);
    end
    hs = 1'b1;
    vs = 1'b1;
    vis = 1'b0;
    col = '0;
    if (n >= 3) begin
      h = (n - 3) % htot;
      v = ((n - 3) / htot) % vtot;
      vis = (h < hact) && (v < vact);
      hs = !((h >= hact + hfp) && (h < hact + hfp + hsw));
      vs = !((v >= vact + vfp) && (v < vact + vfp + vsw));
      if (vis) begin
        px = frc | mem[(v / 4) * 160 + h / 4];
        col = px ? fg : bg;
      end
    end
    return {hs, vs, vis, col, fs, en, addr};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d phase=%0d got=%0h want=%0h", name, cyc, phase, act, exp);
    end
  endtask

  task automatic check_all();
    cmp("pins_dflt", {hsync_d, vsync_d, de_d, rgb_d, fs_d, fb_d.read_en, fb_d.read_addr},
        model(640, 16, 96, 48, 480, 10, 2, 33, D_FG, D_BG, cyc, rst));
    cmp("pins_small", {hsync_s, vsync_s, de_s, rgb_s, fs_s, fb_s.read_en, fb_s.read_addr},
        model(40, 4, 8, 4, 24, 2, 2, 3, S_FG, S_BG, cyc, rst));

    if (phase == 1) begin
      for (int i = 0; i < 9; i++) begin
        if (cyc == vecs[i].v * 800 + vecs[i].h + 1) begin
          cmp("addr_vec", 32'(fb_d.read_addr), vecs[i].addr);
          cmp("en_vec", 32'(fb_d.read_en), 32'(vecs[i].en));
        end
      end
      if (cyc >= 3 && cyc < 6403) begin
        if (!hsync_d) d_hlow++;
        if (!vsync_d) d_vlow++;
        if (de_d) d_de++;
      end
      if (!hsync_d && prev_hs_d) begin
        if (d_fall1 < 0) d_fall1 = cyc;
        else if (d_fall2 < 0) d_fall2 = cyc;
      end
      if (fs_d) d_fs++;
      if (cyc >= 3 && cyc < 3475) begin
        if (!hsync_s) s_hlow++;
        if (!vsync_s) s_vlow++;
        if (de_s) s_de++;
      end
      if (!vsync_s && prev_vs_s) begin
        if (s_vf1 < 0) s_vf1 = cyc;
        else if (s_vf2 < 0) s_vf2 = cyc;
      end
      if (cyc < 3472 && fs_s) s_fs++;
    end

    if (phase == 2) begin
      case (cyc)
        3:    cmp("chk_px_0_0", 32'(rgb_d), 32'(D_BG));
        6:    cmp("chk_px_3_0", 32'(rgb_d), 32'(D_BG));
        7:    cmp("chk_px_4_0", 32'(rgb_d), 32'(D_FG));
        3203: cmp("chk_px_0_4", 32'(rgb_d), 32'(D_FG));
        default: ;
      endcase
    end

    if (phase == 4 && cyc == 0) begin
      cmp("rst_hsync", 32'(hsync_d), 1);
      cmp("rst_vsync", 32'(vsync_d), 1);
      cmp("rst_de", 32'(de_d), 0);
      cmp("rst_rgb", 32'(rgb_d), 0);
      cmp("rst_fs", 32'(fs_d), 0);
      cmp("rst_en", 32'(fb_d.read_en), 0);
      cmp("rst_addr", 32'(fb_d.read_addr), 0);
    end

    if (phase == 5) begin
      case (cyc)
        0:   cmp("fs_after_release", 32'(fs_d), 1);
        2:   cmp("de_before_px0", 32'(de_d), 0);
        3:   cmp("de_px0", 32'(de_d), 1);
        642: cmp("de_px639", 32'(de_d), 1);
        643: cmp("de_px640", 32'(de_d), 0);
        658: cmp("hs_pre_sync", 32'(hsync_d), 1);
        659: cmp("hs_sync_start", 32'(hsync_d), 0);
        754: cmp("hs_sync_last", 32'(hsync_d), 0);
        755: cmp("hs_sync_end", 32'(hsync_d), 1);
        default: ;
      endcase
    end

    if (phase == 6) begin
      if (!de_d && rgb_d != 12'h000) blank_bad++;
      if (!de_s && rgb_s != 12'h000) blank_bad++;
      if (de_s) s_de6++;
      if (de_s && rgb_s == S_FG) s_fg6++;
    end

    prev_hs_d = hsync_d;
    prev_vs_s = vsync_s;
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #5;
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 1'b1};
    vecs[1] = '{3, 3, 0, 1'b1};
    vecs[2] = '{4, 4, 161, 1'b1};
    vecs[3] = '{639, 3, 159, 1'b1};
    vecs[4] = '{639, 4, 319, 1'b1};
    vecs[5] = '{640, 4, 0, 1'b0};
    vecs[6] = '{799, 7, 0, 1'b0};
    vecs[7] = '{101, 7, 185, 1'b1};
    vecs[8] = '{159, 5, 199, 1'b1};

    for (int a = 0; a < 19200; a++) mem[a] = 1'($urandom);

    // power-on reset, then random image
    @(posedge clk);
    #5;
    repeat (2) step();
    rst = 1'b0;
    phase = 1;
    repeat (6410) step();

    cmp("d_hsync_low", d_hlow, 768);
    cmp("d_de_high", d_de, 5120);
    cmp("d_vsync_low", d_vlow, 0);
    cmp("d_hs_first_fall", d_fall1, 659);
    cmp("d_hs_period", d_fall2 - d_fall1, 800);
    cmp("d_frame_start", d_fs, 1);
    cmp("s_hsync_low", s_hlow, 496);
    cmp("s_vsync_low", s_vlow, 224);
    cmp("s_de_high", s_de, 1920);
    cmp("s_frame_start", s_fs, 2);
    cmp("s_vs_first_fall", s_vf1, 1459);
    cmp("s_vs_period", s_vf2 - s_vf1, 1736);

    // checkerboard image
    rst = 1'b1;
    phase = 0;
    repeat (2) step();
    for (int a = 0; a < 19200; a++) mem[a] = 1'(((a % 160) ^ (a / 160)) & 1);
    rst = 1'b0;
    phase = 2;
    repeat (3210) step();

    // reset mid-line at S0 = (300,2), held over two edges
    rst = 1'b1;
    phase = 0;
    repeat (2) step();
    for (int a = 0; a < 19200; a++) mem[a] = 1'($urandom);
    rst = 1'b0;
    phase = 3;
    repeat (1900) step();
    rst = 1'b1;
    phase = 4;
    repeat (2) step();
    rst = 1'b0;
    phase = 5;
    repeat (810) step();

    // blanking with read_data stuck high
    rst = 1'b1;
    phase = 0;
    repeat (2) step();
    frc = 1'b1;
    rst = 1'b0;
    phase = 6;
    repeat (3482) step();

    cmp("blank_rgb_nonzero", blank_bad, 0);
    cmp("s_forced_fg", s_fg6, s_de6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
